// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED status engine.
package led_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CH_W   = 4;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_CODE  = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_P_ON  = 2'd1,
    C_P_OFF = 2'd2,
    C_GAP   = 2'd3
  } code_state_e;

  function automatic int unsigned ticks_per_ms(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: pattern counters, CODE sequencer and raw (unpolarised) lit level.
module led_chan
  import led_pkg::*;
#(
  parameter int unsigned BLINK_MS = 500,
  parameter int unsigned PULSE_MS = 200,
  parameter int unsigned GAP_MS   = 1000,
  parameter led_mode_e   RST_MODE = LED_OFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr,
  input  led_mode_e         wr_mode,
  input  logic [CODE_W-1:0] wr_code,
  output logic              lit_c
);

  led_mode_e         mode;
  code_state_e       state;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] pulses;
  logic [CNT_W-1:0]  cnt;
  logic              blink_off;
  logic              at_last;
  logic              counting;

  // Current phase reaches its final tick.
  always_comb begin
    at_last = 1'b0;
    if (mode == LED_BLINK)   at_last = (cnt == CNT_W'(BLINK_MS - 1));
    else if (state == C_GAP) at_last = (cnt == CNT_W'(GAP_MS - 1));
    else                     at_last = (cnt == CNT_W'(PULSE_MS - 1));
  end

  assign counting = (mode == LED_BLINK) || ((mode == LED_CODE) && (state != C_IDLE));

  // A write restarts the pattern and takes priority over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= RST_MODE;
      state     <= C_IDLE;
      code      <= '0;
      pulses    <= '0;
      cnt       <= '0;
      blink_off <= 1'b0;
    end else if (wr) begin
      mode      <= wr_mode;
      code      <= wr_code;
      pulses    <= wr_code;
      cnt       <= '0;
      blink_off <= 1'b0;
      state     <= ((wr_mode == LED_CODE) && (wr_code != '0)) ? C_P_ON : C_IDLE;
    end else if (tick && counting) begin
      if (!at_last) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        if (mode == LED_BLINK) begin
          blink_off <= ~blink_off;
        end else begin
          unique case (state)
            C_P_ON: begin
              pulses <= pulses - CODE_W'(1);
              state  <= (pulses == CODE_W'(1)) ? C_GAP : C_P_OFF;
            end
            C_P_OFF: state <= C_P_ON;
            C_GAP: begin
              pulses <= code;
              state  <= C_P_ON;
            end
            default: state <= C_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    lit_c = 1'b0;
    unique case (mode)
      LED_ON:    lit_c = 1'b1;
      LED_BLINK: lit_c = ~blink_off;
      LED_CODE:  lit_c = (state == C_P_ON);
      default:   lit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status engine: 1 ms prescaler, config write port, per-channel pattern engines.
module led_status_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned NUM_LEDS        = 5,
  parameter int unsigned BLINK_MS        = 500,
  parameter int unsigned PULSE_MS        = 200,
  parameter int unsigned GAP_MS          = 1000,
  parameter int unsigned LED_ACTIVE_LOW  = 0,
  parameter int unsigned RESET_HEARTBEAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CODE_W-1:0]   cfg_code,
  output logic                cfg_err,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned TPM   = ticks_per_ms(CLK_HZ);
  localparam int unsigned PRE_W = (TPM > 1) ? $clog2(TPM) : 1;
  localparam logic        POL   = (LED_ACTIVE_LOW != 0);

  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic                accept;
  logic                in_range;
  logic [NUM_LEDS-1:0] raw;

  assign tick     = (pre_cnt == PRE_W'(TPM - 1));
  assign accept   = cfg_valid && cfg_ready;
  assign in_range = (32'(cfg_ch) < NUM_LEDS);

  // Free-running ms prescaler; never realigned by config writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_chan #(
      .BLINK_MS (BLINK_MS),
      .PULSE_MS (PULSE_MS),
      .GAP_MS   (GAP_MS),
      .RST_MODE (((i == 0) && (RESET_HEARTBEAT != 0)) ? LED_BLINK : LED_OFF)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .wr      (accept && in_range && (cfg_ch == CH_W'(i))),
      .wr_mode (led_mode_e'(cfg_mode)),
      .wr_code (cfg_code),
      .lit_c   (raw[i])
    );
  end

  // Handshake throttles to one write per two clocks; leds follow channels one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      leds      <= {NUM_LEDS{POL}};
    end else begin
      cfg_ready <= ~accept;
      cfg_err   <= accept && !in_range;
      leds      <= raw ^ {NUM_LEDS{POL}};
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed self-checking bench for led_status_ctrl (active-high and active-low instances).
module tb_led_status_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       cfg_valid, cfg_valid2;
  logic [3:0] cfg_ch, cfg_ch2;
  logic [1:0] cfg_mode, cfg_mode2;
  logic [3:0] cfg_code, cfg_code2;
  logic       cfg_ready, cfg_ready2;
  logic       cfg_err, cfg_err2;
  logic [4:0] leds, leds2;

  int checks   = 0;
  int failures = 0;
  int e        = 0;
  int rises;
  logic prev;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .CLK_HZ(10_000), .NUM_LEDS(5), .BLINK_MS(3), .PULSE_MS(2), .GAP_MS(5),
    .LED_ACTIVE_LOW(0), .RESET_HEARTBEAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_code(cfg_code),
    .cfg_err(cfg_err), .leds(leds)
  );

  led_status_ctrl #(
    .CLK_HZ(10_000), .NUM_LEDS(5), .BLINK_MS(3), .PULSE_MS(2), .GAP_MS(5),
    .LED_ACTIVE_LOW(1), .RESET_HEARTBEAT(1)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .cfg_ch(cfg_ch2), .cfg_mode(cfg_mode2), .cfg_code(cfg_code2),
    .cfg_err(cfg_err2), .leds(leds2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    e += n;
    #1;
  endtask

  task automatic step_to(input int target);
    while (e < target) step(1);
  endtask

  // Present a write so that it is accepted on edge at_edge.
  task automatic wr(input int unit, input int ch, input int mode, input int code, input int at_edge);
    step_to(at_edge - 1);
    if (unit == 1) begin
      cfg_valid = 1'b1; cfg_ch = 4'(ch); cfg_mode = 2'(mode); cfg_code = 4'(code);
    end else begin
      cfg_valid2 = 1'b1; cfg_ch2 = 4'(ch); cfg_mode2 = 2'(mode); cfg_code2 = 4'(code);
    end
    step(1);
    cfg_valid  = 1'b0;
    cfg_valid2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_code = '0;
    cfg_valid2 = 1'b0; cfg_ch2 = '0; cfg_mode2 = '0; cfg_code2 = '0;

    // Reset values
    step(2);
    chk("rst_leds", 32'(leds), 32'h00);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_leds_al", 32'(leds2), 32'h1F);

    // Heartbeat on ch0 from first clk, toggles every 30 clk
    rst_n = 1'b1; rst2_n = 1'b1; e = 0;
    step_to(1);
    chk("hb_e1", 32'(leds), 32'h01);
    chk("hb_e1_al", 32'(leds2), 32'h1E);
    step_to(30);  chk("hb_e30", 32'(leds), 32'h01);
    step_to(31);  chk("hb_e31", 32'(leds), 32'h00);
    step_to(61);  chk("hb_e61", 32'(leds), 32'h01);

    // ch2 ON
    wr(1, 2, 1, 0, 65);
    chk("on_ready_n1", 32'(cfg_ready), 32'd0);
    chk("on_leds_n1", 32'(leds), 32'h01);
    step(1);
    chk("on_ready_n2", 32'(cfg_ready), 32'd1);
    chk("on_leds_n2", 32'(leds), 32'h05);

    // Out-of-range channel
    wr(1, 7, 1, 0, 70);
    chk("oor_err_n1", 32'(cfg_err), 32'd1);
    chk("oor_ready_n1", 32'(cfg_ready), 32'd0);
    chk("oor_leds_n1", 32'(leds), 32'h05);
    step(1);
    chk("oor_err_n2", 32'(cfg_err), 32'd0);
    chk("oor_ready_n2", 32'(cfg_ready), 32'd1);
    chk("oor_leds_n2", 32'(leds), 32'h05);

    // ch1 CODE 3
    wr(1, 1, 3, 3, 75);
    chk("code_err", 32'(cfg_err), 32'd0);
    step(1);      chk("code_e76", 32'(leds[1]), 32'd1);
    step_to(90);  chk("code_e90", 32'(leds[1]), 32'd1);
    step_to(91);  chk("code_e91", 32'(leds[1]), 32'd0);
    step_to(110); chk("code_e110", 32'(leds[1]), 32'd0);
    step_to(111); chk("code_e111", 32'(leds[1]), 32'd1);
    step_to(131); chk("code_e131", 32'(leds[1]), 32'd0);
    step_to(151); chk("code_e151", 32'(leds[1]), 32'd1);
    step_to(171); chk("code_e171", 32'(leds[1]), 32'd0);
    step_to(220); chk("code_e220", 32'(leds[1]), 32'd0);
    prev = leds[1];
    rises = 0;
    while (e < 370) begin
      step(1);
      if (leds[1] && !prev) rises++;
      prev = leds[1];
    end
    chk("code_frame_rises", 32'(rises), 32'd3);
    step_to(371); chk("code_e371", 32'(leds[1]), 32'd1);
    step_to(391); chk("code_e391", 32'(leds[1]), 32'd0);

    // Rewrite during P_OFF restarts at P_ON
    wr(1, 1, 3, 3, 395);
    chk("rw_e395", 32'(leds[1]), 32'd0);
    step(1);      chk("rw_e396", 32'(leds[1]), 32'd1);
    step_to(410); chk("rw_e410", 32'(leds[1]), 32'd1);
    step_to(411); chk("rw_e411", 32'(leds[1]), 32'd0);

    // Write coinciding with a tick
    wr(1, 1, 3, 3, 420);
    step(1);      chk("rwt_e421", 32'(leds[1]), 32'd1);
    step_to(440); chk("rwt_e440", 32'(leds[1]), 32'd1);
    step_to(441); chk("rwt_e441", 32'(leds[1]), 32'd0);
    step_to(455); chk("rwt_e455", 32'(leds[1]), 32'd0);
    step_to(461); chk("rwt_e461", 32'(leds[1]), 32'd1);

    // Active-low instance: ON then CODE with code 0
    wr(2, 3, 1, 0, 480);
    step(1);      chk("al_on", 32'(leds2[3]), 32'd0);
    wr(2, 3, 3, 0, 490);
    step(1);      chk("al_code0_e491", 32'(leds2[3]), 32'd1);
    step_to(560); chk("al_code0_e560", 32'(leds2[3]), 32'd1);

    // Async reset mid-BLINK, between clock edges
    step_to(565);
    chk("al_hb_lit", 32'(leds2[0]), 32'd0);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("al_async_rst", 32'(leds2), 32'h1F);
    #10;
    rst2_n = 1'b1;
    step(1);
    chk("al_after_rst", 32'(leds2), 32'h1E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
